keypad_scanner: RTL and testbench

KEYPAD_SCANNER -- requirements
Module: keypad_scanner

---
 rtl/keypad_pkg.sv | 22 ++
 rtl/keypad_debounce.sv | 35 +++
 rtl/keypad_scanner.sv | 147 ++++++++++++++
 tb/tb_keypad_scanner.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/keypad_pkg.sv
// Shared definitions for the keypad scanner: FSM encoding and width helpers.
package keypad_pkg;

    localparam logic [1:0] ST_SCAN     = 2'd0;
    localparam logic [1:0] ST_DEBOUNCE = 2'd1;
    localparam logic [1:0] ST_HOLD     = 2'd2;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) begin
            r = r + 1;
        end
        return r;
    endfunction

    // Register width for n distinct values, never narrower than one bit.
    function automatic int width_of(input int n);
        return (clog2(n) < 1) ? 1 : clog2(n);
    endfunction

endpackage

// File: rtl/keypad_debounce.sv
// Consecutive stable-cycle counter shared by the press and release filters.
module keypad_debounce
    import keypad_pkg::*;
#(
    parameter int CYCLES = 8
) (
    input  logic clk,
    input  logic reset,
    input  logic i_level,
    input  logic i_expect,
    input  logic i_restart,
    output logic o_done
);

    localparam int CNT_W = width_of(CYCLES);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(CYCLES - 1);

    logic [CNT_W-1:0] r_cnt;
    logic             w_match;

    assign w_match = (i_level == i_expect);
    // Done on the CYCLES-th matching cycle, visible in that same cycle.
    assign o_done  = w_match && (r_cnt == LAST);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt <= '0;
        end else if (i_restart || !w_match) begin
            r_cnt <= '0;
        end else if (r_cnt != LAST) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/keypad_scanner.sv
// Matrix keypad scanner: rotating column drive, debounced press/release,
// single-entry key buffer with overrun flag.
module keypad_scanner
    import keypad_pkg::*;
#(
    parameter  int ROWS            = 4,
    parameter  int COLS            = 3,
    parameter  int SCAN_DIV        = 4,
    parameter  int DEBOUNCE_CYCLES = 8,
    localparam int CODE_W          = width_of(ROWS * COLS)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ROWS-1:0]   row,
    output logic [COLS-1:0]   col,
    output logic [CODE_W-1:0] key_code,
    output logic              key_valid,
    input  logic              key_ack,
    output logic              overrun
);

    localparam int RW = width_of(ROWS);
    localparam int CW = width_of(COLS);
    localparam int DW = width_of(SCAN_DIV);
    localparam logic [CW-1:0] LAST_COL = CW'(COLS - 1);
    localparam logic [DW-1:0] LAST_DIV = DW'(SCAN_DIV - 1);

    logic [1:0]        r_state;
    logic [DW-1:0]     r_div;
    logic [CW-1:0]     r_col_idx;
    logic [RW-1:0]     r_row_idx;
    logic [CODE_W-1:0] r_code;
    logic              r_valid;
    logic              r_overrun;

    logic [RW-1:0]     w_low_row;
    logic [CW-1:0]     w_next_col;
    logic [CODE_W-1:0] w_new_code;
    logic              w_any_row;
    logic              w_db_level;
    logic              w_db_expect;
    logic              w_db_restart;
    logic              w_db_done;
    logic              w_load;

    assign w_any_row  = |row;
    assign w_next_col = (r_col_idx == LAST_COL) ? '0 : r_col_idx + 1'b1;
    assign w_new_code = CODE_W'(r_row_idx * COLS + r_col_idx);

    // Lowest set row wins when several rows are active.
    always_comb begin
        w_low_row = '0;
        for (int i = ROWS - 1; i >= 0; i--) begin
            if (row[i]) begin
                w_low_row = RW'(i);
            end
        end
    end

    // DEBOUNCE tracks the latched row staying high; HOLD tracks all rows low.
    assign w_db_level   = (r_state == ST_HOLD) ? w_any_row : row[r_row_idx];
    assign w_db_expect  = (r_state != ST_HOLD);
    assign w_db_restart = (r_state == ST_SCAN) || w_db_done;
    assign w_load       = (r_state == ST_DEBOUNCE) && w_db_done;

    keypad_debounce #(
        .CYCLES (DEBOUNCE_CYCLES)
    ) u_debounce (
        .clk       (clk),
        .reset     (reset),
        .i_level   (w_db_level),
        .i_expect  (w_db_expect),
        .i_restart (w_db_restart),
        .o_done    (w_db_done)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= ST_SCAN;
            r_div     <= '0;
            r_col_idx <= '0;
            r_row_idx <= '0;
        end else begin
            case (r_state)
                ST_SCAN: begin
                    if (r_div == LAST_DIV) begin
                        r_div <= '0;
                        if (w_any_row) begin
                            r_row_idx <= w_low_row;
                            r_state   <= ST_DEBOUNCE;
                        end else begin
                            r_col_idx <= w_next_col;
                        end
                    end else begin
                        r_div <= r_div + 1'b1;
                    end
                end
                ST_DEBOUNCE: begin
                    if (!row[r_row_idx]) begin
                        r_state   <= ST_SCAN;
                        r_col_idx <= w_next_col;
                        r_div     <= '0;
                    end else if (w_db_done) begin
                        r_state <= ST_HOLD;
                    end
                end
                ST_HOLD: begin
                    if (w_db_done) begin
                        r_state   <= ST_SCAN;
                        r_col_idx <= w_next_col;
                        r_div     <= '0;
                    end
                end
                default: begin
                    r_state <= ST_SCAN;
                    r_div   <= '0;
                end
            endcase
        end
    end

    // A load while the previous code is unread and unacknowledged is dropped.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_code    <= '0;
            r_valid   <= 1'b0;
            r_overrun <= 1'b0;
        end else if (w_load) begin
            if (r_valid && !key_ack) begin
                r_overrun <= 1'b1;
            end else begin
                r_code    <= w_new_code;
                r_valid   <= 1'b1;
                r_overrun <= 1'b0;
            end
        end else if (key_ack && r_valid) begin
            r_valid   <= 1'b0;
            r_overrun <= 1'b0;
        end
    end

    assign col       = COLS'(1) << r_col_idx;
    assign key_code  = r_code;
    assign key_valid = r_valid;
    assign overrun   = r_overrun;

endmodule

// File: tb/tb_keypad_scanner.sv
// Scoreboard bench for keypad_scanner at default parameters.
module tb_keypad_scanner;

    logic       clk;
    logic       reset;
    logic [3:0] row;
    logic [2:0] col;
    logic [3:0] key_code;
    logic       key_valid;
    logic       key_ack;
    logic       overrun;

    int errors = 0;
    int checks = 0;
    int exp_q[$];
    logic prev_v = 1'b0;

    keypad_scanner dut (
        .clk       (clk),
        .reset     (reset),
        .row       (row),
        .col       (col),
        .key_code  (key_code),
        .key_valid (key_valid),
        .key_ack   (key_ack),
        .overrun   (overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Monitor: every new key_valid assertion must match the next queued code.
    always @(negedge clk) begin
        if (key_valid === 1'b1 && !prev_v) begin
            if (exp_q.size() == 0) chk("unexpected_key_valid", 32'(key_valid), 0);
            else chk("key_code", 32'(key_code), exp_q.pop_front());
        end
        prev_v = (key_valid === 1'b1);
    end

    task automatic wait_col(input logic [2:0] target);
        int n = 0;
        while (col !== target && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk("wait_col", 32'(col), 32'(target));
    endtask

    task automatic wait_flag(input bit want_ovr, input string name);
        int n = 0;
        while ((want_ovr ? overrun : key_valid) !== 1'b1 && n < 21) begin
            @(negedge clk);
            n++;
        end
        chk(name, 32'(want_ovr ? overrun : key_valid), 1);
    endtask

    task automatic ack_pulse();
        key_ack = 1'b1;
        @(negedge clk);
        key_ack = 1'b0;
    endtask

    task automatic release_row(input logic [2:0] held, input logic [2:0] nxt);
        row = 4'b0000;
        repeat (7) @(negedge clk);
        chk("hold_frozen", 32'(col), 32'(held));
        @(negedge clk);
        chk("hold_exit", 32'(col), 32'(nxt));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        row = 4'b0000;
        key_ack = 1'b0;
        reset = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst_col", 32'(col), 32'b001);
        chk("rst_valid", 32'(key_valid), 0);
        chk("rst_code", 32'(key_code), 0);
        chk("rst_ovr", 32'(overrun), 0);
        reset = 1'b0;
        repeat (3) @(negedge clk);
        chk("col_dwell", 32'(col), 32'b001);
        @(negedge clk);
        chk("col_step", 32'(col), 32'b010);
        repeat (8) @(negedge clk);
        chk("col_wrap", 32'(col), 32'b001);

        // Key at row 0, column 0
        row = 4'b0001;
        exp_q.push_back(0);
        wait_flag(1'b0, "latency_k0");
        chk("frozen_k0", 32'(col), 32'b001);
        ack_pulse();
        chk("ack_clears", 32'(key_valid), 0);
        release_row(3'b001, 3'b010);

        // Bounce: three cycles high during DEBOUNCE
        row = 4'b0010;
        repeat (5) @(negedge clk);
        chk("deb_frozen", 32'(col), 32'b010);
        repeat (2) @(negedge clk);
        row = 4'b0000;
        @(negedge clk);
        chk("bounce_next_col", 32'(col), 32'b100);
        chk("bounce_no_valid", 32'(key_valid), 0);

        // Row 3, column 2 -> 11
        row = 4'b1000;
        exp_q.push_back(11);
        wait_flag(1'b0, "latency_k11");
        chk("frozen_k11", 32'(col), 32'b100);
        ack_pulse();
        release_row(3'b100, 3'b001);

        // Rows 1 and 3 at column 1 -> 1*3+1
        wait_col(3'b010);
        row = 4'b1010;
        exp_q.push_back(4);
        wait_flag(1'b0, "latency_k4");
        ack_pulse();
        release_row(3'b010, 3'b100);

        // Two presses without ack
        wait_col(3'b001);
        row = 4'b0001;
        exp_q.push_back(0);
        wait_flag(1'b0, "latency_first");
        release_row(3'b001, 3'b010);
        row = 4'b0100;
        wait_flag(1'b1, "overrun_set");
        chk("ovr_code_kept", 32'(key_code), 0);
        chk("ovr_valid", 32'(key_valid), 1);
        chk("ovr_hold_col", 32'(col), 32'b010);
        ack_pulse();
        chk("ack_valid", 32'(key_valid), 0);
        chk("ack_ovr", 32'(overrun), 0);
        ack_pulse();
        chk("idle_ack", 32'(key_valid), 0);
        release_row(3'b010, 3'b100);

        // Leave a key unread, then reset mid-DEBOUNCE
        row = 4'b0001;
        exp_q.push_back(2);
        wait_flag(1'b0, "latency_k2");
        release_row(3'b100, 3'b001);
        wait_col(3'b010);
        row = 4'b0001;
        repeat (6) @(negedge clk);
        chk("pre_rst_col", 32'(col), 32'b010);
        #2 reset = 1'b1;
        #1;
        chk("async_col", 32'(col), 32'b001);
        chk("async_valid", 32'(key_valid), 0);
        chk("async_code", 32'(key_code), 0);
        chk("async_ovr", 32'(overrun), 0);
        row = 4'b0000;
        @(negedge clk);
        reset = 1'b0;
        repeat (3) @(negedge clk);
        chk("restart_col0", 32'(col), 32'b001);
        @(negedge clk);
        chk("restart_col1", 32'(col), 32'b010);
        repeat (30) @(negedge clk);
        chk("abandoned", 32'(key_valid), 0);

        chk("queue_empty", 32'(exp_q.size()), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
